// File: rtl/cpu_pkg.sv
// Shared definitions for the bus-based CPU: opcodes, one-hot sub-FSM selects,
// dispatcher state encoding and instruction field positions.
package cpu_pkg;

  localparam logic [3:0] paraAdd   = 4'b0001;
  localparam logic [3:0] paraSub   = 4'b0010;
  localparam logic [3:0] paraAnd   = 4'b0011;
  localparam logic [3:0] paraOr    = 4'b0100;
  localparam logic [3:0] paraXor   = 4'b0101;
  localparam logic [3:0] paraShl   = 4'b0110;
  localparam logic [3:0] paraNot   = 4'b0111;
  localparam logic [3:0] paraAddi  = 4'b1000;
  localparam logic [3:0] paraSubi  = 4'b1001;
  localparam logic [3:0] paraMove  = 4'b1010;
  localparam logic [3:0] paraMovi  = 4'b1011;
  localparam logic [3:0] paraLoad  = 4'b1100;
  localparam logic [3:0] paraStore = 4'b1101;

  localparam int SEL_W = 7;

  localparam logic [SEL_W-1:0] stateAluPar2 = 7'b0000001;
  localparam logic [SEL_W-1:0] stateAluPar1 = 7'b0000010;
  localparam logic [SEL_W-1:0] stateAluNot  = 7'b0000100;
  localparam logic [SEL_W-1:0] stateMove    = 7'b0001000;
  localparam logic [SEL_W-1:0] stateMovi    = 7'b0010000;
  localparam logic [SEL_W-1:0] stateLoad    = 7'b0100000;
  localparam logic [SEL_W-1:0] stateStore   = 7'b1000000;
  localparam logic [SEL_W-1:0] stateError   = 7'b1111111;

  localparam logic [2:0] S_FETCH    = 3'd0;
  localparam logic [2:0] S_WAIT_MFC = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_DISPATCH = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_PCINC    = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int P1_HI  = 11;
  localparam int P1_LO  = 6;
  localparam int P2_HI  = 5;
  localparam int P2_LO  = 0;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decoder: maps a 4-bit opcode to the one-hot sub-FSM
// select and flags opcodes that have no execution sub-FSM.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [3:0]       i_opcode,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_illegal
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    o_sel     = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      paraAdd, paraSub, paraAnd,
      paraOr, paraXor, paraShl: o_sel = stateAluPar2;
      paraAddi, paraSubi:       o_sel = stateAluPar1;
      paraNot:                  o_sel = stateAluNot;
      paraMove:                 o_sel = stateMove;
      paraMovi:                 o_sel = stateMovi;
      paraLoad:                 o_sel = stateLoad;
      paraStore:                o_sel = stateStore;
      default:                  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_dispatch_fsm.sv
// Top-level instruction sequencer: fetch via MFC handshake, decode, start one
// execution sub-FSM, wait for its done pulse, bump the PC and repeat.
module fetch_dispatch_fsm
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int IW      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    instrIn,
  input  logic             mfc,
  input  logic [SEL_W-1:0] doneVec,
  output logic             memRead,
  output logic             pcOut,
  output logic             pcInc,
  output logic [SEL_W-1:0] nextFSM,
  output logic [5:0]       para1,
  output logic [5:0]       para2,
  output logic [3:0]       aluOp,
  output logic             errFlag
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [IW-1:0]    r_ir;
  logic [SEL_W-1:0] r_sel;
  logic [5:0]       r_para1;
  logic [5:0]       r_para2;
  logic [3:0]       r_alu_op;
  logic [CW-1:0]    r_cnt;

  logic [SEL_W-1:0] w_sel;
  logic             w_illegal;

  opcode_decoder u_dec (
    .i_opcode  (r_ir[OPC_HI:OPC_LO]),
    .o_sel     (w_sel),
    .o_illegal (w_illegal)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_ir     <= '0;
      r_sel    <= '0;
      r_para1  <= '0;
      r_para2  <= '0;
      r_alu_op <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_WAIT_MFC;
        S_WAIT_MFC: begin
          if (mfc) begin
            r_ir    <= instrIn;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_para1  <= r_ir[P1_HI:P1_LO];
          r_para2  <= r_ir[P2_HI:P2_LO];
          r_alu_op <= r_ir[OPC_HI:OPC_LO];
          r_sel    <= w_sel;
          r_state  <= w_illegal ? S_ERROR : S_DISPATCH;
        end
        S_DISPATCH: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          // A done from the selected sub-FSM wins even on the last allowed cycle.
          if (|(doneVec & r_sel))       r_state <= S_PCINC;
          else if (|(doneVec & ~r_sel)) r_state <= S_ERROR;
          else if (r_cnt == CNT_LAST)   r_state <= S_ERROR;
        end
        S_PCINC: r_state <= S_FETCH;
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_ERROR;
      endcase
    end
  end

  always_comb begin
    memRead = 1'b0;
    pcOut   = 1'b0;
    pcInc   = 1'b0;
    nextFSM = '0;
    errFlag = 1'b0;
    case (r_state)
      // Bus requests are masked while rst is held so reset shows all-zero outputs.
      S_FETCH, S_WAIT_MFC: begin
        memRead = ~rst;
        pcOut   = ~rst;
      end
      S_DISPATCH: nextFSM = r_sel;
      S_PCINC:    pcInc   = 1'b1;
      S_ERROR: begin
        nextFSM = stateError;
        errFlag = 1'b1;
      end
      default: ;
    endcase
  end

  assign para1 = r_para1;
  assign para2 = r_para2;
  assign aluOp = r_alu_op;

endmodule

// File: tb/tb_fetch_dispatch_fsm.sv
// Self-checking bench for fetch_dispatch_fsm: dispatch scoreboard plus
// per-scenario cycle-accurate checks.
module tb_fetch_dispatch_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instrIn;
  logic        mfc;
  logic [6:0]  doneVec;
  logic        memRead, pcOut, pcInc, errFlag;
  logic [6:0]  nextFSM;
  logic [5:0]  para1, para2;
  logic [3:0]  aluOp;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [6:0] sel;
    logic [5:0] p1;
    logic [5:0] p2;
    logic [3:0] op;
  } exp_t;

  exp_t sb[$];

  fetch_dispatch_fsm #(.TIMEOUT(32), .IW(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .instrIn (instrIn),
    .mfc     (mfc),
    .doneVec (doneVec),
    .memRead (memRead),
    .pcOut   (pcOut),
    .pcInc   (pcInc),
    .nextFSM (nextFSM),
    .para1   (para1),
    .para2   (para2),
    .aluOp   (aluOp),
    .errFlag (errFlag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp_sel(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: exp_sel = 7'b0000001;
      4'd8, 4'd9:                         exp_sel = 7'b0000010;
      4'd7:                               exp_sel = 7'b0000100;
      4'd10:                              exp_sel = 7'b0001000;
      4'd11:                              exp_sel = 7'b0010000;
      4'd12:                              exp_sel = 7'b0100000;
      4'd13:                              exp_sel = 7'b1000000;
      default:                            exp_sel = 7'b0000000;
    endcase
  endfunction

  // Every single-bit start pulse must match the oldest expected dispatch.
  always @(negedge clk) begin
    if (!rst && nextFSM !== 7'h00 && nextFSM !== 7'h7F) begin
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_dispatch: nextFSM=%b with nothing expected", nextFSM);
      end else begin
        e = sb.pop_front();
        if ({nextFSM, para1, para2, aluOp} !== e) begin
          n_fail++;
          $display("FAIL dispatch: got sel=%b p1=%0d p2=%0d op=%h expected sel=%b p1=%0d p2=%0d op=%h",
                   nextFSM, para1, para2, aluOp, e.sel, e.p1, e.p2, e.op);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; mfc = 1'b0; doneVec = '0;
    step; step;
    rst = 1'b0;
    #1;
  endtask

  task automatic push_exp(input logic [15:0] instr);
    exp_t e;
    e.sel = exp_sel(instr[15:12]);
    e.p1  = instr[11:6];
    e.p2  = instr[5:0];
    e.op  = instr[15:12];
    sb.push_back(e);
  endtask

  // Starts in a FETCH cycle (cycle 0); returns in cycle 3.
  task automatic issue(input logic [15:0] instr);
    instrIn = instr;
    step;
    mfc = 1'b1;
    step;
    mfc = 1'b0;
    instrIn = 16'($urandom);
    step;
  endtask

  task automatic test_reset;
    rst = 1'b1; instrIn = '0; mfc = 1'b0; doneVec = '0;
    step; step;
    n_checks++;
    if ({memRead, pcOut, pcInc, nextFSM, para1, para2, aluOp, errFlag} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {memRead, pcOut, pcInc, nextFSM, para1, para2, aluOp, errFlag});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({memRead, pcOut} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release: memRead/pcOut=%b expected 11", {memRead, pcOut});
    end
    push_exp(16'hB0C7);
    issue(16'hB0C7);
    step; step;
    n_checks++;
    if ({para1, para2, aluOp} !== {6'd3, 6'd7, 4'hB}) begin
      n_fail++;
      $display("FAIL movi_fields: got %0d %0d %h expected 3 7 b", para1, para2, aluOp);
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step;
      n_checks++;
      if ({memRead, pcOut, pcInc, nextFSM, para1, para2, aluOp, errFlag} !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_wait: cycle %0d got %h expected 0", c,
                 {memRead, pcOut, pcInc, nextFSM, para1, para2, aluOp, errFlag});
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({memRead, pcOut, pcInc} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_mid_wait_release: memRead/pcOut/pcInc=%b expected 110",
               {memRead, pcOut, pcInc});
    end
  endtask

  task automatic test_addi;
    logic pcinc_seen = 1'b0;
    push_exp(16'h8045);
    instrIn = 16'h8045;
    step;                       // cycle 1
    mfc = 1'b1;
    step;                       // cycle 2
    mfc = 1'b0;
    n_checks++;
    if (nextFSM !== 7'h00) begin
      n_fail++;
      $display("FAIL addi_decode_cycle: nextFSM=%b expected 0", nextFSM);
    end
    step;                       // cycle 3
    n_checks++;
    if (nextFSM !== 7'b0000010) begin
      n_fail++;
      $display("FAIL addi_dispatch_cycle: nextFSM=%b expected 0000010", nextFSM);
    end
    for (int c = 4; c <= 16; c++) begin
      step;
      if (nextFSM !== 7'h00 || pcInc !== 1'b0) pcinc_seen = 1'b1;
    end
    n_checks++;
    if (pcinc_seen) begin
      n_fail++;
      $display("FAIL addi_wait_quiet: nextFSM/pcInc active got 1 expected 0");
    end
    doneVec = 7'b0000010;
    step;                       // cycle 17
    doneVec = '0;
    n_checks++;
    if ({pcInc, memRead, para1, para2, aluOp} !== {1'b1, 1'b0, 6'd1, 6'd5, 4'h8}) begin
      n_fail++;
      $display("FAIL addi_pcinc: got pcInc=%b memRead=%b p1=%0d p2=%0d op=%h expected 1 0 1 5 8",
               pcInc, memRead, para1, para2, aluOp);
    end
    step;                       // cycle 18
    n_checks++;
    if ({memRead, pcInc} !== 2'b10) begin
      n_fail++;
      $display("FAIL addi_next_fetch: memRead/pcInc=%b expected 10", {memRead, pcInc});
    end
  endtask

  task automatic test_mfc_delay;
    logic bad = 1'b0;
    push_exp(16'hA0C3);
    instrIn = 16'hA0C3;
    for (int c = 1; c <= 5; c++) begin
      step;
      if (memRead !== 1'b1 || pcOut !== 1'b1 || nextFSM !== 7'h00) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL mfc_delay_hold: memRead dropped or decode early, got 1 expected 0");
    end
    mfc = 1'b1;
    step;                       // DECODE
    mfc = 1'b0;
    n_checks++;
    if (memRead !== 1'b0) begin
      n_fail++;
      $display("FAIL mfc_delay_decode: memRead=%b expected 0", memRead);
    end
    step;                       // DISPATCH
    n_checks++;
    if (nextFSM !== 7'b0001000) begin
      n_fail++;
      $display("FAIL mov_dispatch: nextFSM=%b expected 0001000", nextFSM);
    end
    step;                       // WAIT
    mfc = 1'b1;
    instrIn = 16'h1FFF;
    step;
    mfc = 1'b0;
    n_checks++;
    if ({memRead, nextFSM, para1, para2, aluOp} !== {1'b0, 7'h00, 6'd3, 6'd3, 4'hA}) begin
      n_fail++;
      $display("FAIL mfc_ignored_in_wait: got memRead=%b nextFSM=%b p1=%0d p2=%0d op=%h expected 0 0 3 3 a",
               memRead, nextFSM, para1, para2, aluOp);
    end
    doneVec = 7'b0001000;
    step;
    doneVec = '0;
    n_checks++;
    if (pcInc !== 1'b1) begin
      n_fail++;
      $display("FAIL mov_pcinc: pcInc=%b expected 1", pcInc);
    end
    step;
  endtask

  task automatic test_timeout;
    logic bad = 1'b0;
    push_exp(16'hC0C0);
    issue(16'hC0C0);            // cycle 3
    for (int c = 4; c <= 35; c++) step;
    n_checks++;
    if ({nextFSM, errFlag} !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout_last_wait: nextFSM=%b errFlag=%b expected 0 0", nextFSM, errFlag);
    end
    step;                       // cycle 36
    n_checks++;
    if ({nextFSM, errFlag} !== {7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_error: nextFSM=%b errFlag=%b expected 1111111 1", nextFSM, errFlag);
    end
    for (int c = 0; c < 4; c++) begin
      mfc = c[0];
      doneVec = (c < 2) ? 7'b0100000 : 7'h7F;
      step;
      if ({nextFSM, errFlag, memRead, pcInc} !== {7'h7F, 1'b1, 1'b0, 1'b0}) bad = 1'b1;
    end
    mfc = 1'b0;
    doneVec = '0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL error_sticky: left ERROR got 1 expected 0");
    end
    do_reset;
    n_checks++;
    if (errFlag !== 1'b0) begin
      n_fail++;
      $display("FAIL error_cleared: errFlag=%b expected 0", errFlag);
    end
  endtask

  task automatic test_illegal;
    logic [3:0] ops [3] = '{4'h0, 4'hE, 4'hF};
    for (int i = 0; i < 3; i++) begin
      issue({ops[i], 12'($urandom)});
      n_checks++;
      if ({nextFSM, errFlag} !== {7'h7F, 1'b1}) begin
        n_fail++;
        $display("FAIL illegal_op_%h: nextFSM=%b errFlag=%b expected 1111111 1",
                 ops[i], nextFSM, errFlag);
      end
      step;
      do_reset;
    end
  endtask

  task automatic test_wrong_done;
    push_exp(16'hD105);
    issue(16'hD105);
    step;                       // WAIT
    doneVec = 7'b0000001;
    step;
    doneVec = '0;
    n_checks++;
    if ({nextFSM, errFlag, pcInc} !== {7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrong_done: nextFSM=%b errFlag=%b pcInc=%b expected 1111111 1 0",
               nextFSM, errFlag, pcInc);
    end
    do_reset;
  endtask

  task automatic test_done_at_timeout;
    logic [15:0] instr = {4'hD, 12'($urandom)};
    push_exp(instr);
    issue(instr);               // cycle 3
    for (int c = 4; c <= 35; c++) step;
    doneVec = 7'b1000000;       // same cycle as counter == 31
    step;
    doneVec = '0;
    n_checks++;
    if ({pcInc, errFlag, nextFSM} !== {1'b1, 1'b0, 7'h00}) begin
      n_fail++;
      $display("FAIL done_at_timeout: pcInc=%b errFlag=%b nextFSM=%b expected 1 0 0",
               pcInc, errFlag, nextFSM);
    end
    step;
    n_checks++;
    if (memRead !== 1'b1) begin
      n_fail++;
      $display("FAIL done_at_timeout_fetch: memRead=%b expected 1", memRead);
    end
  endtask

  task automatic test_back_to_back;
    for (int op = 1; op <= 13; op++) begin
      logic [15:0] instr = {4'(op), 12'($urandom)};
      push_exp(instr);
      issue(instr);
      step;                     // WAIT
      doneVec = exp_sel(4'(op));
      step;
      doneVec = '0;
      n_checks++;
      if ({pcInc, errFlag} !== 2'b10) begin
        n_fail++;
        $display("FAIL b2b_pcinc_op%0d: pcInc=%b errFlag=%b expected 1 0", op, pcInc, errFlag);
      end
      step;
    end
  endtask

  initial begin
    rst = 1'b1; instrIn = '0; mfc = 1'b0; doneVec = '0;
    test_reset;
    test_addi;
    test_mfc_delay;
    test_timeout;
    test_illegal;
    test_wrong_done;
    test_done_at_timeout;
    test_back_to_back;
    step; step;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d dispatches never seen, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
